// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: reads a burst of words from a first-word-fall-through FIFO
// and replays them on a registered valid/ready stream.
// Ports: start/burst_len = burst command; busy/done/timeout_err/xfer_count = status;
//        fifo_rd_en/fifo_rd_data/fifo_empty = FIFO read port;
//        m_valid/m_data/m_last/m_ready = downstream stream.
module fifo_burst_reader #(
    parameter int WIDTH   = 8,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [LEN_W-1:0] xfer_count,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             fifo_empty,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready
);
    localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state, state_nx;
    logic [LEN_W-1:0] rem, rem_nx, cnt_nx;
    logic [SW-1:0]    stall, stall_nx;
    logic [WIDTH-1:0] data_nx;
    logic             valid_nx, last_nx, done_nx, err_nx;
    logic             out_free, xfer;

    assign out_free   = !m_valid || m_ready;
    assign xfer       = m_valid && m_ready;
    assign busy       = state != IDLE;
    assign fifo_rd_en = (state == BURST) && (rem != '0) && !fifo_empty && out_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rem         <= '0;
            stall       <= '0;
            xfer_count  <= '0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_last      <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            rem         <= rem_nx;
            stall       <= stall_nx;
            xfer_count  <= cnt_nx;
            m_valid     <= valid_nx;
            m_data      <= data_nx;
            m_last      <= last_nx;
            done        <= done_nx;
            timeout_err <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        stall_nx = stall;
        cnt_nx   = xfer_count + LEN_W'(xfer);
        valid_nx = m_valid;
        data_nx  = m_data;
        last_nx  = m_last;
        done_nx  = 1'b0;
        err_nx   = timeout_err;
        if (state == IDLE) begin
            if (start) begin
                rem_nx   = burst_len;
                stall_nx = '0;
                cnt_nx   = '0;
                err_nx   = 1'b0;
                state_nx = (burst_len != '0) ? BURST : IDLE;
                done_nx  = (burst_len == '0);
            end
        end else begin
            if (xfer) valid_nx = 1'b0;
            if (fifo_rd_en) begin
                valid_nx = 1'b1;
                data_nx  = fifo_rd_data;
                last_nx  = (rem == LEN_W'(1));
                rem_nx   = rem - LEN_W'(1);
                stall_nx = '0;
            end else if ((rem != '0) && fifo_empty) begin
                if (stall != SW'(TIMEOUT)) stall_nx = stall + SW'(1);
                // the TIMEOUT-th starved cycle cancels the rest of the burst
                if ((TIMEOUT > 0) && (stall == SW'(TIMEOUT - 1))) begin
                    rem_nx = '0;
                    err_nx = 1'b1;
                end
            end
            // nothing left to pop and the output register drains this cycle
            if ((rem == '0) && out_free) begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed bench for fifo_burst_reader with a queue-based FIFO model.
module tb_fifo_burst_reader;
    localparam int WIDTH   = 8;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] burst_len = '0;
    logic             busy, done, timeout_err, fifo_rd_en, m_valid, m_last;
    logic [LEN_W-1:0] xfer_count;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] fifo_rd_data = '0;
    logic             fifo_empty = 1'b1;
    logic             m_ready = 1'b1;

    fifo_burst_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len),
        .busy(busy), .done(done), .timeout_err(timeout_err), .xfer_count(xfer_count),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int words;
        int len;
        bit toggle;
        int exp_count;
        bit exp_err;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         cyc;
    } beat_t;

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] q[$];
    beat_t      beats[$];
    int         pops[$];
    int         dones[$];
    bit         toggle_rdy = 1'b0;
    logic       pv_stall = 1'b0;
    logic [7:0] pv_data = '0;
    logic       pv_last = 1'b0;
    vec_t       vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic refresh();
        fifo_empty   = (q.size() == 0);
        fifo_rd_data = (q.size() != 0) ? q[0] : 8'hEE;
    endtask

    task automatic clear_logs();
        beats.delete();
        pops.delete();
        dones.delete();
    endtask

    // one clock: observe at the falling edge, update the FIFO model after the rising edge
    task automatic step();
        logic do_pop;
        @(negedge clk);
        if (m_valid && !m_ready) chk("no_pop_while_stalled", fifo_rd_en, 0);
        if (pv_stall) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, pv_data);
            chk("hold_last", m_last, pv_last);
        end
        if (done) begin
            dones.push_back(cyc);
            chk("busy_low_at_done", busy, 0);
        end
        if (m_valid && m_ready) beats.push_back('{m_data, m_last, cyc});
        if (fifo_rd_en) pops.push_back(cyc);
        pv_stall = m_valid && !m_ready;
        pv_data  = m_data;
        pv_last  = m_last;
        do_pop   = fifo_rd_en;
        @(posedge clk);
        #1;
        cyc++;
        if (do_pop) void'(q.pop_front());
        if (toggle_rdy) m_ready = !m_ready;
        refresh();
    endtask

    task automatic load(input int n, input logic [7:0] base);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(base + 8'(i));
        refresh();
    endtask

    task automatic run_vec(input vec_t v, input logic [7:0] base);
        load(v.words, base);
        clear_logs();
        m_ready    = 1'b1;
        toggle_rdy = v.toggle;
        start      = 1'b1;
        burst_len  = LEN_W'(v.len);
        step();
        start = 1'b0;
        for (int t = 0; t < 200 && dones.size() == 0; t++) step();
        toggle_rdy = 1'b0;
        m_ready    = 1'b1;
        chk("done_seen", dones.size(), 1);
        chk("beat_count", beats.size(), v.exp_count);
        chk("xfer_count", xfer_count, v.exp_count);
        chk("timeout_err", timeout_err, v.exp_err);
        chk("fifo_words_left", q.size(), (v.words > v.len) ? v.words - v.len : 0);
        chk("valid_low_after", m_valid, 0);
        for (int i = 0; i < beats.size() && i < v.exp_count; i++) begin
            chk("beat_data", beats[i].data, base + 8'(i));
            chk("beat_last", beats[i].last, (!v.exp_err && i == v.exp_count - 1) ? 1 : 0);
        end
        if (!v.exp_err && dones.size() > 0 && beats.size() > 0)
            chk("done_latency", dones[0] - beats[beats.size()-1].cyc, 1);
        if (v.exp_err && dones.size() > 0 && pops.size() > 0)
            chk("timeout_latency", dones[0] - pops[pops.size()-1], 10);
        if (!v.toggle && !v.exp_err)
            for (int i = 1; i < beats.size(); i++)
                chk("back_to_back", beats[i].cyc - beats[0].cyc, i);
        q.delete();
        refresh();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        vecs[0] = '{5, 5, 1'b0, 5, 1'b0};
        vecs[1] = '{5, 5, 1'b1, 5, 1'b0};
        vecs[2] = '{8, 3, 1'b0, 3, 1'b0};
        vecs[3] = '{1, 1, 1'b1, 1, 1'b0};
        vecs[4] = '{2, 4, 1'b0, 2, 1'b1};
        refresh();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        chk("rst_count", xfer_count, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) run_vec(vecs[i], (i < 2) ? 8'h10 : 8'h30 + 8'(i * 16));

        // zero-length burst right after a timed-out one
        load(1, 8'h55);
        clear_logs();
        start     = 1'b1;
        burst_len = '0;
        step();
        start = 1'b0;
        step();
        step();
        chk("zero_done_pulses", dones.size(), 1);
        chk("zero_no_pop", pops.size(), 0);
        chk("zero_fifo_intact", q.size(), 1);
        chk("zero_count", xfer_count, 0);
        chk("zero_err_cleared", timeout_err, 0);
        chk("zero_busy", busy, 0);

        // starvation shorter than the timeout, then the burst completes
        load(2, 8'hA0);
        clear_logs();
        start     = 1'b1;
        burst_len = 8'd4;
        step();
        start = 1'b0;
        for (int t = 0; t < 20 && pops.size() < 2; t++) step();
        repeat (5) step();
        q.push_back(8'hA2);
        refresh();
        repeat (6) step();
        chk("starve_no_done", dones.size(), 0);
        chk("starve_busy", busy, 1);
        chk("starve_no_err", timeout_err, 0);
        q.push_back(8'hA3);
        refresh();
        for (int t = 0; t < 50 && dones.size() == 0; t++) step();
        chk("starve_done", dones.size(), 1);
        chk("starve_beats", beats.size(), 4);
        chk("starve_count", xfer_count, 4);
        chk("starve_err", timeout_err, 0);
        for (int i = 0; i < beats.size() && i < 4; i++) begin
            chk("starve_data", beats[i].data, 8'hA0 + 8'(i));
            chk("starve_last", beats[i].last, (i == 3) ? 1 : 0);
        end

        // a second start during an active burst is ignored
        load(3, 8'hC0);
        clear_logs();
        m_ready   = 1'b0;
        start     = 1'b1;
        burst_len = 8'd3;
        step();
        start = 1'b0;
        repeat (2) step();
        start     = 1'b1;
        burst_len = 8'd9;
        step();
        start   = 1'b0;
        m_ready = 1'b1;
        for (int t = 0; t < 50 && dones.size() == 0; t++) step();
        repeat (3) step();
        chk("restart_done_once", dones.size(), 1);
        chk("restart_count", xfer_count, 3);
        chk("restart_beats", beats.size(), 3);
        chk("restart_idle", busy, 0);
        q.delete();
        refresh();

        // asynchronous reset with a held beat
        load(4, 8'hD0);
        clear_logs();
        m_ready   = 1'b0;
        start     = 1'b1;
        burst_len = 8'd4;
        step();
        start = 1'b0;
        repeat (2) step();
        chk("pre_reset_valid", m_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_valid", m_valid, 0);
        chk("areset_busy", busy, 0);
        chk("areset_done", done, 0);
        chk("areset_count", xfer_count, 0);
        chk("areset_data", m_data, 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        pv_stall = 1'b0;
        m_ready  = 1'b1;
        q.delete();
        refresh();
        clear_logs();
        step();
        chk("areset_no_done", dones.size(), 0);
        run_vec(vecs[0], 8'h10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side companion to the team's synchronous FIFO (first-word-fall-through read data, `rd_en`/`empty` read port).
- On a `start` command it pulls exactly `burst_len` words from the FIFO and presents them downstream on a registered valid/ready stream, with `m_last` on the final beat.
- Reports completion with a `done` pulse and a word count.
- Aborts with an error flag if the FIFO stays empty for too long mid-burst.

Parameters:
- WIDTH, 8, data word width; must match the FIFO WIDTH.
- LEN_W, 8, width of `burst_len` and `xfer_count`; maximum burst is 2^LEN_W-1.
- TIMEOUT, 64, consecutive starved cycles before a burst is aborted; 0 disables the timeout.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  burst request; sampled only in IDLE.
- burst_len  input  LEN_W  number of words to read; sampled with `start`.
- busy  output  1  high while not in IDLE.
- done  output  1  one-cycle completion pulse.
- timeout_err  output  1  last burst ended by timeout; valid from `done`, held until the next accepted `start`.
- xfer_count  output  LEN_W  beats accepted downstream in the current or last burst.
- fifo_rd_en  output  1  FIFO pop; combinational.
- fifo_rd_data  input  WIDTH  FIFO head word, valid whenever `fifo_empty`=0.
- fifo_empty  input  1  FIFO empty flag.
- m_valid  output  WIDTH/1  output beat valid (1 bit).
- m_data  output  WIDTH  output beat data.
- m_last  output  1  final beat of the burst.
- m_ready  input  1  downstream accept.

Behaviour:
- Reset (async, `rst_n`=0): state IDLE. `busy`, `done`, `timeout_err`, `m_valid`, `m_last` = 0. `m_data` = 0, `xfer_count` = 0. Remaining and stall counters = 0.
- Output register:
  - A beat transfers when `m_valid`&&`m_ready`.
  - Once `m_valid` is high, `m_data`/`m_last` are stable until transfer; `m_valid` never drops without a transfer.
  - `out_free` = !`m_valid` || `m_ready`.
- State IDLE:
  - `start` with `burst_len`>0: load remaining=`burst_len`, clear `xfer_count`, `timeout_err` and stall counter; go to BURST.
  - `start` with `burst_len`=0: no FIFO read, stay IDLE, `done`=1 next cycle with `xfer_count`=0 and `timeout_err`=0.
  - `start` outside IDLE is ignored.
- State BURST:
  - `fifo_rd_en` = (remaining>0) && !`fifo_empty` && `out_free`. It is never asserted in any other state or condition.
  - On a pop:
    - `m_data`<=`fifo_rd_data`, `m_valid`<=1.
    - `m_last`<=(remaining==1).
    - remaining<=remaining-1.
    - Stall counter<=0.
  - On a transfer with no pop in the same cycle: `m_valid`<=0.
  - Every transfer increments `xfer_count`.
- Latency and throughput:
  - FIFO non-empty with the output free gives `m_valid`=1 on the next cycle.
  - With `m_ready` held high and the FIFO non-empty, throughput is 1 word/cycle (pop and transfer in the same cycle).
- Termination:
  - Normal end: the transfer of the `m_last` beat moves the block to IDLE.
  - `done`=1 on the following cycle; `busy` drops the same cycle `done` rises.
- Timeout (TIMEOUT>0):
  - The stall counter increments each BURST cycle with remaining>0 and `fifo_empty`=1, and saturates.
  - When it reaches TIMEOUT: remaining<=0 and `timeout_err`<=1.
  - A word already held in the output register is still delivered, with `m_last`=0.
  - The block returns to IDLE once the output register is empty; `done` pulses on the next cycle.
  - A starved `m_ready` does not count toward the timeout; only FIFO starvation does.
- Simultaneous events:
  - A pop and a transfer in the same cycle keep `m_valid`=1 with the new data.
  - `fifo_empty` rising in the cycle after a pop causes no read.
- Arithmetic: remaining and `xfer_count` are LEN_W bits, with no wrap, since at most `burst_len` beats are transferred.
- Reset mid-burst: immediate return to the reset values; the held beat is discarded and no `done` is issued.

Test Plan:
- FIFO preloaded with 0x10..0x14, `burst_len`=5, `m_ready`=1: `m_valid` 1 cycle after `start` for 5 consecutive cycles with `m_data` 0x10..0x14; `m_last` only on 0x14; `done` 1 cycle after that beat; `xfer_count`=5; `timeout_err`=0.
- Same setup with `m_ready` toggling 1,0,1,0: `m_data` stable while stalled; no `fifo_rd_en` while `m_valid`&&!`m_ready`; all 5 words delivered in order.
- FIFO holds 2 words, `burst_len`=4, TIMEOUT=8, no further writes: 2 beats delivered with `m_last`=0; `done` pulses about 8 cycles after the second pop; `timeout_err`=1; `xfer_count`=2.
- Same as above but a third word is written after 5 starved cycles: stall counter clears, no timeout; the fourth word written later completes the burst with `m_last` on it.
- `start` with `burst_len`=0: `done` next cycle; `xfer_count`=0; `fifo_rd_en` never asserted. A second `start` asserted during an active burst is ignored (`xfer_count` unchanged).
- `rst_n` pulsed low mid-burst with a held beat: `m_valid`, `busy`, `done` = 0 immediately; a fresh burst afterwards behaves as in scenario 1.
